// File: rtl/star_frame_writer.sv
// Writer side of the star-image RAM: optional background clear pass, then a
// row-major pixel stream written to y*WIDTH+x, with frameWritten once complete.
module star_frame_writer #(
  parameter int xSz    = 3,
  parameter int ySz    = 3,
  parameter int addrSz = 6,
  parameter int colSz  = 3,
  parameter int WIDTH  = 6,
  parameter int HEIGHT = 6,
  parameter int BGCOL  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clearEn,
  input  logic              pixValid,
  input  logic [colSz-1:0]  pixData,
  output logic              pixReady,
  output logic [addrSz-1:0] mem_address,
  output logic [colSz-1:0]  mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              frameWritten
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DONE
  } stateT;

  localparam logic [xSz-1:0]   xLast   = xSz'(WIDTH - 1);
  localparam logic [ySz-1:0]   yLast   = ySz'(HEIGHT - 1);
  localparam logic [colSz-1:0] bgValue = colSz'(BGCOL);

  stateT             state;
  stateT             nextState;
  logic [xSz-1:0]    xCount;
  logic [ySz-1:0]    yCount;
  logic              atLast;
  logic              doWrite;
  logic              advance;
  logic              clrCnt;
  logic [colSz-1:0]  wrData;

  // Same zero-extended y*WIDTH + x mapping the edge finders use when reading.
  function automatic logic [addrSz-1:0] pixAddr(input logic [xSz-1:0] x,
                                                input logic [ySz-1:0] y);
    logic [addrSz-1:0] xExt;
    logic [addrSz-1:0] yExt;
    xExt = addrSz'(x);
    yExt = addrSz'(y);
    return yExt * addrSz'(WIDTH) + xExt;
  endfunction

  assign atLast       = (xCount == xLast) && (yCount == yLast);
  assign pixReady     = (state == STREAM);
  assign busy         = (state == CLEAR) || (state == STREAM);
  assign frameWritten = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    doWrite   = 1'b0;
    advance   = 1'b0;
    clrCnt    = 1'b0;
    wrData    = pixData;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          clrCnt    = 1'b1;
          nextState = clearEn ? CLEAR : STREAM;
        end
      end
      CLEAR: begin
        doWrite = 1'b1;
        advance = 1'b1;
        wrData  = bgValue;
        if (atLast) begin
          nextState = STREAM;
        end
      end
      STREAM: begin
        if (pixValid) begin
          doWrite = 1'b1;
          advance = 1'b1;
          if (atLast) begin
            nextState = DONE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Raster counters: x wraps at the row end and carries into y; y wraps after the last row.
  always_ff @(posedge clk) begin
    if (reset || clrCnt) begin
      xCount <= '0;
      yCount <= '0;
    end else if (advance) begin
      if (xCount == xLast) begin
        xCount <= '0;
        yCount <= (yCount == yLast) ? '0 : yCount + 1'b1;
      end else begin
        xCount <= xCount + 1'b1;
      end
    end
  end

  // Registered RAM port: the write decided this cycle is presented next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      mem_wren <= doWrite;
      if (doWrite) begin
        mem_address <= pixAddr(xCount, yCount);
        mem_data    <= wrData;
      end
    end
  end

endmodule
